// File: rtl/can_tx_arbiter.sv
// can_tx_arbiter: shares the TX message FIFO write port among NUM_REQ mailboxes,
// lowest CAN identifier wins unless a mailbox has lost AGE_LIMIT arbitrations in a row.
module can_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int AGE_LIMIT = 7
) (
   input  logic                   i_sys_clk,
   input  logic                   i_reset,
   input  logic [NUM_REQ-1:0]     i_req,
   input  logic [128*NUM_REQ-1:0] i_req_data,
   output logic [NUM_REQ-1:0]     o_grant,
   input  logic                   i_fifo_full,
   output logic                   o_fifo_w_en,
   output logic [127:0]           o_fifo_w_data,
   output logic                   o_busy,
   output logic                   o_starve_evt
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);
   typedef enum logic [1:0] {IDLE, WAIT_SPACE, WRITE} state_t;
   state_t state, state_nxt;
   logic [IW-1:0] win, pick;
   logic [127:0] frame;
   logic forced, pick_forced, found, take;
   logic [10:0] best_id;
   logic [7:0] age [NUM_REQ];
   assign take = (state == IDLE) && |i_req;
   // Aged requesters override identifier priority; the reverse scan leaves the lowest aged index.
   always_comb begin
      pick = '0;
      pick_forced = 1'b0;
      found = 1'b0;
      best_id = '1;
      for (int k = 0; k < NUM_REQ; k++)
         if (i_req[k] && (!found || i_req_data[128*k+117 +: 11] < best_id)) begin
            found = 1'b1;
            best_id = i_req_data[128*k+117 +: 11];
            pick = IW'(k);
         end
      for (int k = NUM_REQ-1; k >= 0; k--)
         if (i_req[k] && age[k] == AGE_MAX) begin
            pick = IW'(k);
            pick_forced = 1'b1;
         end
   end
   always_comb begin
      state_nxt = (state == IDLE) ? (take ? WAIT_SPACE : IDLE) :
                  (state == WAIT_SPACE) ? (i_fifo_full ? WAIT_SPACE : WRITE) : IDLE;
   end
   always_ff @(posedge i_sys_clk or posedge i_reset)
      if (i_reset) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge i_sys_clk or posedge i_reset)
      if (i_reset) begin
         win <= '0;
         frame <= '0;
         forced <= 1'b0;
         for (int k = 0; k < NUM_REQ; k++) age[k] <= '0;
      end else if (take) begin
         win <= pick;
         frame <= i_req_data[{pick, 7'd0} +: 128];
         forced <= pick_forced;
         for (int k = 0; k < NUM_REQ; k++)
            age[k] <= (IW'(k) == pick || !i_req[k]) ? 8'd0 :
                      (age[k] == AGE_MAX) ? age[k] : age[k] + 8'd1;
      end
   assign o_busy        = (state != IDLE);
   assign o_fifo_w_en   = (state == WRITE);
   assign o_fifo_w_data = (state == WRITE) ? frame : '0;
   assign o_starve_evt  = (state == WRITE) && forced;
   assign o_grant       = (state == WRITE) ? (NUM_REQ'(1) << win) : '0;
endmodule
